console_uart_tx: RTL
====================

# console_uart_tx

Memory-mapped console output stage sitting directly downstream of the RV32I core's store path. It consumes store transactions, buffers bytes written to the console address in a FIFO, and serialises them as 8N1 UART frames on `txd`. An optional exit-register feature captures the program's exit code and reports it only after all buffered console output has drained.

## Interface
Parameters:
- `CLK_DIV`, 16, clock cycles per UART bit; must be ≥ 2.
- `FIFO_DEPTH`, 16, byte FIFO entries; must be a power of two, ≥ 2.
- `CONSOLE_ADDR`, 32'hFFFF0000, store address that emits a character.
- `EXIT_ADDR`, 32'hABCD0000, store address that latches the exit code.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `st_valid`  in  1  core presents a store this cycle.
- `st_addr`  in  32  full byte address of the store.
- `st_data`  in  32  store data; only `[7:0]` is used for console writes.
- `st_ready`  out  1  block accepts the store this cycle.
- `txd`  out  1  serial output; idle high.
- `busy`  out  1  FIFO non-empty or frame in progress.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  bytes currently buffered.
- `exit_valid`  out  1  sticky; exit code latched and output drained.
- `exit_code`  out  32  latched exit value.

## Operation
- A store is accepted on any rising edge where `st_valid && st_ready`. `st_ready = !full`, independent of address.
- Accepted store with `st_addr == CONSOLE_ADDR`: push `st_data[7:0]`. Store with any other address is accepted and dropped (no side effects), except `EXIT_ADDR` when the macro is enabled.
- TX FSM states are IDLE, START, DATA, and STOP. The baud counter reloads to `CLK_DIV-1` on every state or bit change and counts to 0.
  - IDLE: `txd=1`. If the FIFO is non-empty, pop into the shift register and go to START.
  - START: `txd=0` for `CLK_DIV` cycles, then go to DATA with bit index 0.
  - DATA: `txd=shift[0]`, LSB first. After `CLK_DIV` cycles, shift. After bit 7, go to STOP.
  - STOP: `txd=1` for `CLK_DIV` cycles. At the end, if the FIFO is non-empty, pop and go straight to START (no idle gap). Otherwise go to IDLE.
- A frame is exactly `10*CLK_DIV` cycles.
- Width and arithmetic rules:
  - FIFO pointers are `$clog2(FIFO_DEPTH)+1` bits and wrap naturally.
  - full means the MSBs differ and the remaining bits are equal.
  - `fifo_level = wr_ptr - rd_ptr`, truncated to the pointer width.
- Simultaneous push and pop in one cycle is legal when the FIFO is neither empty nor full. `fifo_level` stays unchanged.
- There is no empty-FIFO bypass: a push into an empty FIFO is popped on the following edge.
- When full, `st_ready=0` even if a pop occurs in the same cycle.
- `busy = (state != IDLE) || !empty`.

## Timing
- Reset (`rst_n=0` sampled on an edge) produces:
  - state IDLE, `txd=1`;
  - pointers 0, `fifo_level=0`;
  - `busy=0`, `st_ready=1`;
  - `exit_valid=0`, `exit_code=0`.
- Reset mid-frame aborts the frame and discards all FIFO contents. `txd` is high from the edge after reset.
- `txd` is registered.
- A console store accepted on edge N: `fifo_level=1` after N; pop and START on edge N+1; `txd` low after N+1.
- `st_ready` is valid combinationally from registered state only. It has no combinational path from `st_valid` or `st_addr`.

## Configuration
- Macro: `CONSOLE_UART_EXIT_EN`.
- Defined:
  - An accepted store to `EXIT_ADDR` latches `st_data` into `exit_code` and sets a pending flag.
  - `exit_valid` rises on the first edge where pending && FIFO empty && state IDLE. It stays high until reset.
  - Further exit stores after the first are dropped.
- Undefined: `EXIT_ADDR` is treated as an ordinary non-matching address. `exit_valid` and `exit_code` are tied to 0.

## Structure
- Package `console_pkg` contains:
  - the `tx_state_t` enum (IDLE, START, DATA, STOP);
  - `CONSOLE_ADDR_DEFAULT` and `EXIT_ADDR_DEFAULT` constants;
  - `UART_FRAME_BITS = 10`.
- Sub-module `sync_byte_fifo`: parameterised by depth, with push/pop/full/empty/level ports. The top level holds the decode, TX FSM, baud counter and exit logic.

## Test plan
- `CLK_DIV=4`: console store of 0x41 → start bit low for 4 cycles beginning one edge after accept, then data bits 1,0,0,0,0,0,1,0, then stop high. Frame is 40 cycles; `busy` drops after the stop bit.
- Back-to-back stores of 0x55 and 0xAA → second start bit immediately follows first stop bit. 80 contiguous cycles with no idle high gap.
- `FIFO_DEPTH=4`, six consecutive console stores:
  - first byte is popped, next four fill the FIFO, and `st_ready=0` for the sixth;
  - the sixth is accepted on the edge after the first frame's stop bit completes.
- Store 0x41 to 32'h00000100 → accepted, `fifo_level` stays 0, `txd` stays 1, `busy` stays 0.
- With `CONSOLE_UART_EXIT_EN`: console stores "h" and "i", then exit store of 3 → `exit_code=3`, and `exit_valid` rises only after the second stop bit ends. Without the macro, `exit_valid` stays 0.
- `rst_n` pulled low during DATA bit 3 with 2 bytes queued → after the edge, `txd=1`, `fifo_level=0`, `busy=0`, and no further frames are sent.

Source files
------------

// File: rtl/console_pkg.sv
`default_nettype none
// ============================================================================
// Module   : console_pkg
// Brief    : Shared types and constants for the console UART transmitter.
// Revision : 1.0 - initial release
// ============================================================================
package console_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam logic [31:0] CONSOLE_ADDR_DEFAULT = 32'hFFFF_0000;
    localparam logic [31:0] EXIT_ADDR_DEFAULT    = 32'hABCD_0000;
    localparam int          UART_FRAME_BITS      = 10;

endpackage
`default_nettype wire

// File: rtl/sync_byte_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_byte_fifo
// Brief    : Single-clock byte FIFO with wrap-bit pointers and level output.
// Revision : 1.0 - initial release
// ============================================================================
module sync_byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [7:0]               din,
    input  logic                     pop,
    output logic [7:0]               dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int c_AW = $clog2(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [c_AW:0] r_wr_ptr;
    logic [c_AW:0] r_rd_ptr;
    logic          w_do_push;
    logic          w_do_pop;

    // The extra MSB distinguishes a full FIFO from an empty one.
    assign full      = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                       (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign empty     = (r_wr_ptr == r_rd_ptr);
    assign level     = r_wr_ptr - r_rd_ptr;
    assign dout      = r_mem[r_rd_ptr[c_AW-1:0]];
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[c_AW-1:0]] <= din;
    end

endmodule
`default_nettype wire

// File: rtl/console_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : console_uart_tx
// Brief    : Store-path console sink: buffers console bytes, sends 8N1 frames.
//            Optional exit register enabled by CONSOLE_UART_EXIT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module console_uart_tx
    import console_pkg::*;
#(
    parameter int          CLK_DIV      = 16,
    parameter int          FIFO_DEPTH   = 16,
    parameter logic [31:0] CONSOLE_ADDR = CONSOLE_ADDR_DEFAULT,
    parameter logic [31:0] EXIT_ADDR    = EXIT_ADDR_DEFAULT
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          st_valid,
    input  logic [31:0]                   st_addr,
    input  logic [31:0]                   st_data,
    output logic                          st_ready,
    output logic                          txd,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          exit_valid,
    output logic [31:0]                   exit_code
);

    localparam int                c_BW          = $clog2(CLK_DIV);
    localparam logic [c_BW-1:0]   c_BAUD_RELOAD = c_BW'(CLK_DIV - 1);
    localparam logic [2:0]        c_LAST_BIT    = 3'(UART_FRAME_BITS - 3);

    tx_state_t       r_state;
    tx_state_t       w_state_nxt;
    logic [c_BW-1:0] r_baud;
    logic [c_BW-1:0] w_baud_nxt;
    logic [2:0]      r_bit;
    logic [2:0]      w_bit_nxt;
    logic [7:0]      r_shift;
    logic [7:0]      w_shift_nxt;
    logic            r_txd;
    logic            w_txd_nxt;

    logic            w_accept;
    logic            w_push;
    logic            w_pop;
    logic [7:0]      w_fifo_dout;
    logic            w_full;
    logic            w_empty;

    assign st_ready = !w_full;
    assign w_accept = st_valid && st_ready;
    assign w_push   = w_accept && (st_addr == CONSOLE_ADDR);
    assign busy     = (r_state != IDLE) || !w_empty;
    assign txd      = r_txd;

    sync_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .din   (st_data[7:0]),
        .pop   (w_pop),
        .dout  (w_fifo_dout),
        .full  (w_full),
        .empty (w_empty),
        .level (fifo_level)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = r_baud;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_pop       = 1'b0;

        unique case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = w_fifo_dout;
                    w_state_nxt = START;
                    w_baud_nxt  = c_BAUD_RELOAD;
                end
            end
            START: begin
                if (r_baud == '0) begin
                    w_state_nxt = DATA;
                    w_bit_nxt   = '0;
                    w_baud_nxt  = c_BAUD_RELOAD;
                end else begin
                    w_baud_nxt  = r_baud - c_BW'(1);
                end
            end
            DATA: begin
                if (r_baud == '0) begin
                    w_baud_nxt = c_BAUD_RELOAD;
                    if (r_bit == c_LAST_BIT) begin
                        w_state_nxt = STOP;
                    end else begin
                        w_shift_nxt = {1'b0, r_shift[7:1]};
                        w_bit_nxt   = r_bit + 3'd1;
                    end
                end else begin
                    w_baud_nxt = r_baud - c_BW'(1);
                end
            end
            STOP: begin
                if (r_baud == '0) begin
                    w_baud_nxt = c_BAUD_RELOAD;
                    // Chain straight into the next start bit when a byte waits.
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_shift_nxt = w_fifo_dout;
                        w_state_nxt = START;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_baud_nxt = r_baud - c_BW'(1);
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        w_txd_nxt = 1'b1;
        case (w_state_nxt)
            START:   w_txd_nxt = 1'b0;
            DATA:    w_txd_nxt = w_shift_nxt[0];
            default: w_txd_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_txd   <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_baud  <= w_baud_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_txd   <= w_txd_nxt;
        end
    end

`ifdef CONSOLE_UART_EXIT_EN
    logic        r_exit_seen;
    logic        r_exit_valid;
    logic [31:0] r_exit_code;

    // Only the first exit store counts; the report waits for the line to drain.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_exit_seen  <= 1'b0;
            r_exit_valid <= 1'b0;
            r_exit_code  <= '0;
        end else begin
            if (w_accept && (st_addr == EXIT_ADDR) && !r_exit_seen) begin
                r_exit_seen <= 1'b1;
                r_exit_code <= st_data;
            end
            if (r_exit_seen && w_empty && (r_state == IDLE)) begin
                r_exit_valid <= 1'b1;
            end
        end
    end

    assign exit_valid = r_exit_valid;
    assign exit_code  = r_exit_code;
`else
    logic w_unused;
    assign w_unused   = ^{st_data[31:8], EXIT_ADDR};
    assign exit_valid = 1'b0;
    assign exit_code  = '0;
`endif

endmodule
`default_nettype wire
